// File: rtl/i8088_bus_pkg.sv
// Shared types and constants for the minimum-mode 8088 bus master.
package i8088_bus_pkg;

  typedef enum logic [2:0] {
    TI,
    T1,
    T2,
    T3,
    TW,
    T4,
    TH
  } bus_state_e;

  typedef struct packed {
    logic        write;
    logic        io;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

  // Active-low strobes (RD, WR, DEN)
  localparam logic STROBE_IDLE   = 1'b1;
  localparam logic STROBE_ACTIVE = 1'b0;

  // DTR idles in the transmit direction
  localparam logic DTR_IDLE = 1'b1;

  // IO cycles only carry a 16-bit port address; the upper nibble is forced low
  function automatic logic [19:0] bus_addr(input logic io, input logic [19:0] addr);
    return io ? {4'h0, addr[15:0]} : addr;
  endfunction

endpackage

// File: rtl/i8088_bus_master.sv
// Minimum-mode 8088 bus interface unit: turns valid/ready requests into
// T1-T4 pin sequencing with READY wait states, HOLD/HLDA and a Tw timeout.
module i8088_bus_master
  import i8088_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        READY,
  input  logic        HOLD,
  output logic        HLDA,
  inout  logic [7:0]  AD,
  output logic [11:0] A,
  output logic        IOM,
  output logic        DTR,
  output logic        SSO,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        DEN
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  bus_state_e    state, state_nx;
  logic [CW-1:0] wait_cnt, wait_cnt_nx;
  bus_req_t      cur;
  logic          sso_q;
  logic          err_q;
  logic [7:0]    rdata_q;
  logic          accept;
  logic          done_ok;
  logic          done_timeout;
  logic          strobe;
  logic          ad_oe;
  logic [7:0]    ad_out;

  // Next-state, wait counting and request handshake
  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    accept       = 1'b0;
    done_ok      = 1'b0;
    done_timeout = 1'b0;
    req_ready    = (state == TI || state == T4) && !HOLD && !RESET;
    case (state)
      TI, T4: begin
        if (HOLD) begin
          state_nx = TH;
        end else if (req_valid && req_ready) begin
          accept      = 1'b1;
          wait_cnt_nx = '0;
          state_nx    = T1;
        end else begin
          state_nx = TI;
        end
      end
      T1: state_nx = T2;
      T2: state_nx = T3;
      T3, TW: begin
        if (READY) begin
          done_ok  = 1'b1;
          state_nx = T4;
        end else if (wait_cnt == CW'(MAX_WAIT)) begin
          done_timeout = 1'b1;
          state_nx     = T4;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
          state_nx    = TW;
        end
      end
      TH: if (!HOLD) state_nx = TI;
      default: state_nx = TI;
    endcase
  end

  // State and Tw counter registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= TI;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Captured request, status and response registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cur     <= '{write: DTR_IDLE, io: 1'b0, addr: '0, wdata: '0};
      sso_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cur   <= '{write: req_write, io: req_io,
                   addr: bus_addr(req_io, req_addr), wdata: req_wdata};
        sso_q <= ~req_io;
      end
      if (done_ok) begin
        err_q <= 1'b0;
        if (!cur.write) rdata_q <= AD;
      end else if (done_timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // Pin decode: strobes from state, cycle type from the captured request
  assign strobe    = (state == T2) || (state == T3) || (state == TW);
  assign ALE       = (state == T1);
  assign RD        = (strobe && !cur.write) ? STROBE_ACTIVE : STROBE_IDLE;
  assign WR        = (strobe && cur.write) ? STROBE_ACTIVE : STROBE_IDLE;
  assign DEN       = strobe ? STROBE_ACTIVE : STROBE_IDLE;
  assign IOM       = cur.io;
  assign DTR       = cur.write;
  assign SSO       = sso_q;
  assign A         = cur.addr[19:8];
  assign HLDA      = (state == TH);
  assign rsp_valid = (state == T4);
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

  assign ad_oe  = (state == T1) || (cur.write && (strobe || state == T4));
  assign ad_out = (state == T1) ? cur.addr[7:0] : cur.wdata;
  assign AD     = ad_oe ? ad_out : 'z;

endmodule

// File: tb/tb_i8088_bus_master.sv
// Self-checking bench for i8088_bus_master: directed scenarios plus random
// transactions checked cycle by cycle against a phase-list reference model.
module tb_i8088_bus_master;

  localparam int MAX_WAIT = 16;

  logic        CLK;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        READY;
  logic        HOLD;
  logic        HLDA;
  wire  [7:0]  AD;
  logic [11:0] A;
  logic        IOM, DTR, SSO, ALE, RD, WR, DEN;

  logic [7:0]  ad_drv;
  logic        ad_en;
  assign AD = ad_en ? ad_drv : 8'bz;

  int          tests;
  int          failed;
  logic [7:0]  last_rdata;

  i8088_bus_master #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .READY(READY), .HOLD(HOLD), .HLDA(HLDA), .AD(AD), .A(A),
    .IOM(IOM), .DTR(DTR), .SSO(SSO), .ALE(ALE), .RD(RD), .WR(WR), .DEN(DEN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one transaction and checks every cycle from T1 to T4 against the
  // expected phase list T1, T2, T3, Tw x min(nwait, MAX_WAIT), T4.
  task automatic do_txn(input logic w, input logic io, input logic [19:0] addr,
                        input logic [7:0] wd, input logic [7:0] rd,
                        input int nwait, input int hold_at, input string tag);
    int          tw;
    int          waited;
    logic        err;
    logic        active;
    logic        hold_on;
    logic [19:0] ma;
    logic [7:0]  exp_rd;
    logic [21:0] exp_v, obs;
    tw  = (nwait > MAX_WAIT) ? MAX_WAIT : nwait;
    err = (nwait > MAX_WAIT);
    ma  = io ? {4'h0, addr[15:0]} : addr;
    req_valid = 1'b1; req_write = w; req_io = io; req_addr = addr; req_wdata = wd;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    tests++;
    if (!req_ready) begin
      failed++;
      $display("FAIL %s accept: req_ready=%b after %0d cycles, required 1", tag, req_ready, waited);
      req_valid = 1'b0;
      return;
    end
    @(negedge CLK);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_io = 1'($urandom);
    req_addr = 20'($urandom); req_wdata = 8'($urandom);
    for (int k = 0; k <= 3 + tw; k++) begin
      active  = (k >= 1) && (k <= 2 + tw);
      hold_on = (hold_at >= 0) && (hold_at < k);
      exp_v = {k == 0, !(active && !w), !(active && w), !active, io, w, !io,
               1'b0, k == 3 + tw, (k == 3 + tw) && !hold_on, ma[19:8]};
      obs   = {ALE, RD, WR, DEN, IOM, DTR, SSO, HLDA, rsp_valid, req_ready, A};
      tests++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL %s pins cycle %0d: got ALE,RD,WR,DEN,IOM,DTR,SSO,HLDA,rsp_valid,req_ready,A=%b_%h required %b_%h",
                 tag, k, obs[21:12], obs[11:0], exp_v[21:12], exp_v[11:0]);
      end
      if (k == 0 || w) begin
        tests++;
        if (AD !== ((k == 0) ? ma[7:0] : wd)) begin
          failed++;
          $display("FAIL %s AD cycle %0d: got %h required %h", tag, k, AD, (k == 0) ? ma[7:0] : wd);
        end
      end
      if (k == 3 + tw) begin
        exp_rd = (!w && !err) ? rd : last_rdata;
        tests++;
        if (rsp_err !== err || rsp_rdata !== exp_rd) begin
          failed++;
          $display("FAIL %s response: got err=%b rdata=%h required err=%b rdata=%h",
                   tag, rsp_err, rsp_rdata, err, exp_rd);
        end
        last_rdata = exp_rd;
      end
      READY  = (k >= 2) ? (k - 2 >= nwait) : 1'($urandom);
      ad_en  = (RD == 1'b0);
      ad_drv = rd;
      if (k == hold_at) HOLD = 1'b1;
      @(negedge CLK);
    end
    ad_en = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
    req_addr = '0; req_wdata = '0; READY = 1'b0; HOLD = 1'b0;
    ad_en = 1'b0; ad_drv = '0; last_rdata = '0;
    repeat (3) @(negedge CLK);
    tests++;
    if ({ALE, RD, WR, DEN, IOM, DTR, SSO, HLDA, rsp_valid, req_ready, A} !== {10'b0111010000, 12'h000}) begin
      failed++;
      $display("FAIL reset pins: got %b_%h required %b_%h",
               {ALE, RD, WR, DEN, IOM, DTR, SSO, HLDA, rsp_valid, req_ready}, A, 10'b0111010000, 12'h000);
    end
    tests++;
    if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
      failed++;
      $display("FAIL reset response: got rdata=%h err=%b required 00 0", rsp_rdata, rsp_err);
    end
    RESET = 1'b0;
    @(negedge CLK);
    tests++;
    if (req_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset idle ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_mem_read();
    do_txn(1'b0, 1'b0, 20'h8_0010, 8'h00, 8'hA5, 0, -1, "mem_read");
  endtask

  task automatic test_io_write();
    do_txn(1'b1, 1'b1, 20'h0_0042, 8'h3C, 8'($urandom), 0, -1, "io_write");
    do_txn(1'b1, 1'b1, 20'hF_1234, 8'($urandom), 8'($urandom), 1, -1, "io_write_hiaddr");
  endtask

  task automatic test_wait_states();
    do_txn(1'b0, 1'b0, 20'($urandom), 8'($urandom), 8'($urandom), 2, -1, "wait2");
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 1'b0, 20'($urandom), 8'($urandom), 8'h5A, MAX_WAIT, -1, "wait_max");
    do_txn(1'b0, 1'b0, 20'($urandom), 8'($urandom), 8'hC3, MAX_WAIT + 3, -1, "timeout");
  endtask

  task automatic test_back_to_back();
    logic [19:0] a0, a1;
    logic [7:0]  r0, r1;
    int          waited;
    a0 = 20'($urandom); a1 = 20'($urandom); r0 = 8'($urandom); r1 = 8'($urandom);
    READY = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = a0;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    tests++;
    if (!req_ready) begin
      failed++;
      $display("FAIL b2b accept: req_ready=%b required 1", req_ready);
    end
    @(negedge CLK);
    req_addr = a1;
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (ALE !== (k == 0 || k == 4) || rsp_valid !== (k == 3 || k == 7)) begin
        failed++;
        $display("FAIL b2b cycle %0d: got ALE=%b rsp_valid=%b required %b %b",
                 k, ALE, rsp_valid, k == 0 || k == 4, k == 3 || k == 7);
      end
      if (k == 4) begin
        tests++;
        if (A !== a1[19:8] || AD !== a1[7:0]) begin
          failed++;
          $display("FAIL b2b second address: got %h%h required %h", A, AD, a1);
        end
        req_valid = 1'b0;
      end
      if (k == 3 || k == 7) begin
        tests++;
        if (rsp_rdata !== ((k == 3) ? r0 : r1)) begin
          failed++;
          $display("FAIL b2b rdata cycle %0d: got %h required %h", k, rsp_rdata, (k == 3) ? r0 : r1);
        end
      end
      ad_en  = (RD == 1'b0);
      ad_drv = (k < 4) ? r0 : r1;
      @(negedge CLK);
    end
    ad_en = 1'b0;
    last_rdata = r1;
  endtask

  task automatic test_hold();
    logic [7:0] v;
    do_txn(1'b0, 1'b0, 20'($urandom), 8'($urandom), 8'($urandom), 1, 1, "hold_mid");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'($urandom);
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom);
      ad_en = 1'b1; ad_drv = v;
      #1;
      tests++;
      if ({HLDA, req_ready, ALE, RD, WR, DEN} !== 6'b100111 || AD !== v) begin
        failed++;
        $display("FAIL hold cycle %0d: got HLDA,req_ready,ALE,RD,WR,DEN=%b AD=%h required 100111 %h",
                 k, {HLDA, req_ready, ALE, RD, WR, DEN}, AD, v);
      end
      ad_en = 1'b0;
      @(negedge CLK);
    end
    HOLD = 1'b0; req_valid = 1'b0;
    @(negedge CLK);
    tests++;
    if (HLDA !== 1'b0 || req_ready !== 1'b1 || ALE !== 1'b0) begin
      failed++;
      $display("FAIL hold release: got HLDA=%b req_ready=%b ALE=%b required 0 1 0", HLDA, req_ready, ALE);
    end
    HOLD = 1'b1; req_valid = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      failed++;
      $display("FAIL hold idle ready: got %b required 0", req_ready);
    end
    @(negedge CLK);
    tests++;
    if (HLDA !== 1'b1 || ALE !== 1'b0) begin
      failed++;
      $display("FAIL hold priority: got HLDA=%b ALE=%b required 1 0", HLDA, ALE);
    end
    HOLD = 1'b0; req_valid = 1'b0;
    @(negedge CLK);
    tests++;
    if (HLDA !== 1'b0) begin
      failed++;
      $display("FAIL hold priority release: got HLDA=%b required 0", HLDA);
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    READY = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_io = 1'b1; req_addr = 20'($urandom);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    tests++;
    if (RD !== 1'b0 || DEN !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid pre: got RD=%b DEN=%b required 0 0", RD, DEN);
    end
    #2 RESET = 1'b1;
    #1;
    tests++;
    if ({ALE, RD, WR, DEN, IOM, DTR, SSO, HLDA, rsp_valid, req_ready, A} !== {10'b0111010000, 12'h000}
        || rsp_rdata !== 8'h00) begin
      failed++;
      $display("FAIL reset_mid async: got %b_%h rdata=%h required %b_000 rdata=00",
               {ALE, RD, WR, DEN, IOM, DTR, SSO, HLDA, rsp_valid, req_ready}, A, rsp_rdata, 10'b0111010000);
    end
    #1 RESET = 1'b0;
    last_rdata = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      tests++;
      if (rsp_valid !== 1'b0 || ALE !== 1'b0 || req_ready !== 1'b1) begin
        failed++;
        $display("FAIL reset_mid after %0d: got rsp_valid=%b ALE=%b req_ready=%b required 0 0 1",
                 k, rsp_valid, ALE, req_ready);
      end
    end
  endtask

  task automatic test_random();
    int nwait;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      nwait = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3))
                                         : int'($urandom_range(MAX_WAIT - 1, MAX_WAIT + 2));
      do_txn(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
             nwait, -1, "random");
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_mem_read();
    test_io_write();
    test_wait_states();
    test_back_to_back();
    test_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
